cpu_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the selen pipeline; owns the PC register and the pipelined instruction bus.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/cpu_sync_fifo.sv | 61 ++++++
 rtl/cpu_fetch_unit.sv | 134 +++++++++++++
 tb/tb_cpu_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the selen CPU front end.
package cpu_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam int          ILEN_DEFAULT     = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force an address onto a 4-byte instruction boundary.
    function automatic logic [XLEN_DEFAULT-1:0] word_align(input logic [XLEN_DEFAULT-1:0] addr);
        return {addr[XLEN_DEFAULT-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_sync_fifo.sv
// Synchronous FIFO with push, pop and single-cycle flush.
// The caller must not push when full unless it pops in the same cycle,
// and must not pop when empty.
module cpu_sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write; a flushed push is harmless because the count is cleared.
    // NOTE: the storage array has no reset; the count alone decides which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues pipelined
// Wishbone reads under a credit limit, buffers returned words in a
// prefetch FIFO and hands {instr, pc, pc+4} to decode. Redirects flush
// the FIFO and discard the acks of every request already in flight.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN            = XLEN_DEFAULT,
    parameter int              ILEN            = ILEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    output logic            inst_cyc_out,
    output logic            inst_stb_out,
    output logic [XLEN-1:0] inst_addr_out,
    input  logic            inst_ack_in,
    input  logic [ILEN-1:0] inst_data_in,
    input  logic            inst_stall_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            dec_valid_out,
    input  logic            dec_ready_in,
    output logic [ILEN-1:0] dec_instr_out,
    output logic [XLEN-1:0] dec_pc_out,
    output logic [XLEN-1:0] dec_pc4_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW    = ILEN + XLEN;

    logic [XLEN-1:0]  r_pc;          // address of the current / next request
    logic [XLEN-1:0]  r_ack_pc;      // PC belonging to the next kept ack
    logic             r_stb;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] r_drop;        // acks still to be discarded after a redirect

    logic             w_accept;
    logic             w_ack;
    logic             w_keep;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [FW-1:0]    w_head;
    logic [OUT_W-1:0] w_out_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_stb_next;
    logic [XLEN-1:0]  w_redirect_pc;

    cpu_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_flush (redirect_valid_in),
        .i_wdata ({inst_data_in, r_ack_pc}),
        .o_rdata (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Handshake decode and next-state credit computation.
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        w_accept      = r_stb && !inst_stall_in;
        // Acks with nothing in flight belong to requests abandoned by reset.
        w_ack         = inst_ack_in && (r_outstanding != '0);
        w_keep        = w_ack && (r_drop == '0) && !redirect_valid_in;
        dec_valid_out = !w_fifo_empty && !redirect_valid_in;
        w_fifo_pop    = dec_valid_out && dec_ready_in;
        w_fifo_push   = w_keep && (!w_fifo_full || w_fifo_pop);
        w_out_next    = r_outstanding + OUT_W'(w_accept) - OUT_W'(w_ack);
        w_count_next  = w_fifo_count + CNT_W'(w_fifo_push) - CNT_W'(w_fifo_pop);
        if (redirect_valid_in) begin
            w_count_next = '0;
        end
        // Every in-flight request reserves a FIFO slot, so the FIFO cannot overflow.
        w_stb_next    = (32'(w_out_next) < 32'(MAX_OUTSTANDING)) &&
                        (32'(w_count_next) + 32'(w_out_next) < 32'(FIFO_DEPTH));
        w_redirect_pc = redirect_pc_in & ~XLEN'(3);
    end

    // Bus request state: strobe, in-flight count and fetch PC.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_stb         <= 1'b0;
            r_outstanding <= '0;
            r_pc          <= RESET_PC;
        end else begin
            r_stb         <= w_stb_next;
            r_outstanding <= w_out_next;
            if (redirect_valid_in) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + XLEN'(4);
            end
        end
    end

    // Response side: drop counter for stale acks and PC of the next kept word.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_drop   <= '0;
            r_ack_pc <= RESET_PC;
        end else if (redirect_valid_in) begin
            r_drop   <= w_out_next;
            r_ack_pc <= w_redirect_pc;
        end else begin
            if (w_ack && (r_drop != '0)) begin
                r_drop <= r_drop - OUT_W'(1);
            end
            if (w_fifo_push) begin
                r_ack_pc <= r_ack_pc + XLEN'(4);
            end
        end
    end

    assign inst_stb_out  = r_stb;
    assign inst_cyc_out  = r_stb || (r_outstanding != '0);
    assign inst_addr_out = r_pc;
    assign dec_instr_out = w_head[FW-1:XLEN];
    assign dec_pc_out    = w_head[XLEN-1:0];
    assign dec_pc4_out   = w_head[XLEN-1:0] + XLEN'(4);

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit. Two instances (RESET_PC 0 and
// 0xFFFFFFF8) share the stimulus; the unselected one is held in reset.
module tb_cpu_fetch_unit;
    import cpu_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        dut_sel;

    logic        inst_ack_in;
    logic [31:0] inst_data_in;
    logic        inst_stall_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        dec_ready_in;

    logic        rst_w   [2];
    logic        cyc_w   [2];
    logic        stb_w   [2];
    logic [31:0] addr_w  [2];
    logic        valid_w [2];
    logic [31:0] instr_w [2];
    logic [31:0] pc_w    [2];
    logic [31:0] pc4_w   [2];

    logic        inst_cyc_out;
    logic        inst_stb_out;
    logic [31:0] inst_addr_out;
    logic        dec_valid_out;
    logic [31:0] dec_instr_out;
    logic [31:0] dec_pc_out;
    logic [31:0] dec_pc4_out;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign rst_w[g] = sys_rst || (dut_sel != 1'(g));
        cpu_fetch_unit #(
            .XLEN            (32),
            .ILEN            (32),
            .RESET_PC        ((g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8),
            .FIFO_DEPTH      (4),
            .MAX_OUTSTANDING (2)
        ) u_dut (
            .sys_clk           (sys_clk),
            .sys_rst           (rst_w[g]),
            .inst_cyc_out      (cyc_w[g]),
            .inst_stb_out      (stb_w[g]),
            .inst_addr_out     (addr_w[g]),
            .inst_ack_in       (inst_ack_in),
            .inst_data_in      (inst_data_in),
            .inst_stall_in     (inst_stall_in),
            .redirect_valid_in (redirect_valid_in),
            .redirect_pc_in    (redirect_pc_in),
            .dec_valid_out     (valid_w[g]),
            .dec_ready_in      (dec_ready_in),
            .dec_instr_out     (instr_w[g]),
            .dec_pc_out        (pc_w[g]),
            .dec_pc4_out       (pc4_w[g])
        );
    end

    assign inst_cyc_out  = cyc_w[dut_sel];
    assign inst_stb_out  = stb_w[dut_sel];
    assign inst_addr_out = addr_w[dut_sel];
    assign dec_valid_out = valid_w[dut_sel];
    assign dec_instr_out = instr_w[dut_sel];
    assign dec_pc_out    = pc_w[dut_sel];
    assign dec_pc4_out   = pc4_w[dut_sel];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } dec_exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_req_t;

    dec_exp_t    exp_dec  [$];
    logic [31:0] exp_addr [$];
    bus_req_t    pend     [$];

    int    n_checks  = 0;
    int    n_fail    = 0;
    int    slave_lat = 1;
    int    edge_cnt  = 0;
    int    acc_count = 0;
    string cur_test  = "init";

    // Instruction memory contents: distinct, address-derived words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return word_align(a) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h expected=%h", cur_test, name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic exp_addr_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(start + 32'(4 * i));
    endtask

    task automatic exp_dec_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            pc = start + 32'(4 * i);
            exp_dec.push_back('{pc, mem_word(pc), pc + 32'd4});
        end
    endtask

    task automatic do_reset(input logic sel, input logic [31:0] rpc);
        tick(1);
        sys_rst           = 1'b1;
        dut_sel           = sel;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = '0;
        inst_stall_in     = 1'b0;
        dec_ready_in      = 1'b0;
        slave_lat         = 1;
        tick(2);
        exp_dec.delete();
        exp_addr.delete();
        acc_count = 0;
        sys_rst   = 1'b0;
        check("rst_stb",   32'(inst_stb_out),  32'd0);
        check("rst_cyc",   32'(inst_cyc_out),  32'd0);
        check("rst_valid", 32'(dec_valid_out), 32'd0);
        check("rst_addr",  inst_addr_out,      rpc);
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while ((exp_dec.size() != 0 || exp_addr.size() != 0) && c < max_cycles) begin
            tick(1);
            c++;
        end
        check("drain_left", 32'(exp_dec.size() + exp_addr.size()), 32'd0);
    endtask

    // Pipelined slave: an accept at edge k is acked in the cycle after edge k+lat-1.
    always @(posedge sys_clk) begin
        int       k;
        bus_req_t r;
        k = edge_cnt;
        edge_cnt++;
        if (sys_rst) begin
            pend.delete();
        end else if (inst_stb_out && !inst_stall_in) begin
            r.addr = inst_addr_out;
            r.due  = k + slave_lat - 1;
            pend.push_back(r);
        end
        #1;
        if (pend.size() > 0 && pend[0].due <= k) begin
            inst_ack_in  = 1'b1;
            inst_data_in = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            inst_ack_in  = 1'b0;
            inst_data_in = INSTR_NOP;
        end
    end

    // Request monitor: every accepted request is checked against the expected address order.
    always @(negedge sys_clk) begin
        if (!sys_rst && inst_stb_out && !inst_stall_in) begin
            acc_count++;
            if (exp_addr.size() > 0) check("req_addr", inst_addr_out, exp_addr.pop_front());
        end
    end

    // Decode monitor: every handshake is checked against the scoreboard head.
    always @(negedge sys_clk) begin
        if (!sys_rst && dec_valid_out && dec_ready_in && exp_dec.size() > 0) begin
            dec_exp_t e;
            e = exp_dec.pop_front();
            check("dec_pc",    dec_pc_out,    e.pc);
            check("dec_instr", dec_instr_out, e.instr);
            check("dec_pc4",   dec_pc4_out,   e.pc4);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        sys_rst           = 1'b1;
        dut_sel           = 1'b0;
        inst_ack_in       = 1'b0;
        inst_data_in      = INSTR_NOP;
        inst_stall_in     = 1'b0;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = '0;
        dec_ready_in      = 1'b0;

        // 1: zero-wait streaming, first-request and first-valid latency, 1 instr/cycle.
        cur_test = "t1";
        do_reset(1'b0, 32'h0);
        exp_addr_seq(32'h0, 8);
        exp_dec_seq(32'h0, 8);
        dec_ready_in = 1'b1;
        tick(1);
        check("first_stb",  32'(inst_stb_out), 32'd1);
        check("first_addr", inst_addr_out,     32'h0);
        tick(1);
        check("valid_early", 32'(dec_valid_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("valid_stream", 32'(dec_valid_out), 32'd1);
        end
        wait_drain(100);
        dec_ready_in = 1'b0;

        // 2: decode back-pressure fills the FIFO, then drains and fetch resumes at 0x10.
        cur_test = "t2";
        do_reset(1'b0, 32'h0);
        exp_addr_seq(32'h0, 8);
        exp_dec_seq(32'h0, 8);
        tick(12);
        check("req_count", 32'(acc_count),     32'd4);
        check("stb_full",  32'(inst_stb_out),  32'd0);
        check("cyc_full",  32'(inst_cyc_out),  32'd0);
        check("valid",     32'(dec_valid_out), 32'd1);
        check("head_pc",   dec_pc_out,         32'h0);
        dec_ready_in = 1'b1;
        wait_drain(100);
        dec_ready_in = 1'b0;

        // 3: slave stall holds stb/addr at 0x8 for three cycles.
        cur_test = "t3";
        do_reset(1'b0, 32'h0);
        exp_addr_seq(32'h0, 8);
        exp_dec_seq(32'h0, 8);
        dec_ready_in = 1'b1;
        tick(3);
        check("pre_stall_addr", inst_addr_out, 32'h8);
        inst_stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_stb",  32'(inst_stb_out), 32'd1);
            check("stall_addr", inst_addr_out,     32'h8);
        end
        inst_stall_in = 1'b0;
        tick(1);
        check("post_stall_addr", inst_addr_out, 32'hC);
        wait_drain(100);
        dec_ready_in = 1'b0;

        // 4: redirect while 0x20 and 0x24 are both in flight.
        cur_test = "t4";
        do_reset(1'b0, 32'h0);
        slave_lat = 4;
        exp_addr.push_back(32'h20);
        exp_addr.push_back(32'h24);
        exp_addr_seq(32'h100, 8);
        exp_dec_seq(32'h100, 8);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h20;
        tick(1);
        redirect_valid_in = 1'b0;
        tick(3);
        check("inflight_stb", 32'(inst_stb_out),  32'd0);
        check("inflight_cyc", 32'(inst_cyc_out),  32'd1);
        check("inflight_vld", 32'(dec_valid_out), 32'd0);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h100;
        dec_ready_in      = 1'b1;
        tick(1);
        redirect_valid_in = 1'b0;
        wait_drain(200);
        dec_ready_in = 1'b0;

        // 5: redirect coincides with ack of 0x28 and accept of 0x2C; low pc bits ignored.
        cur_test = "t5";
        do_reset(1'b0, 32'h0);
        exp_addr_seq(32'h20, 4);
        exp_addr_seq(32'h200, 8);
        exp_dec_seq(32'h200, 8);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h20;
        tick(1);
        redirect_valid_in = 1'b0;
        tick(3);
        check("coinc_addr", inst_addr_out,     32'h2C);
        check("coinc_stb",  32'(inst_stb_out), 32'd1);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h203;
        dec_ready_in      = 1'b1;
        tick(1);
        redirect_valid_in = 1'b0;
        check("target_addr", inst_addr_out, 32'h200);
        wait_drain(200);
        dec_ready_in = 1'b0;

        // 7: back-to-back redirects, the second wins and drops the accepted 0x300.
        cur_test = "t7";
        do_reset(1'b0, 32'h0);
        slave_lat = 2;
        exp_addr.push_back(32'h300);
        exp_addr_seq(32'h400, 8);
        exp_dec_seq(32'h400, 8);
        dec_ready_in      = 1'b1;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h300;
        tick(1);
        redirect_pc_in    = 32'h400;
        tick(1);
        redirect_valid_in = 1'b0;
        wait_drain(200);
        dec_ready_in = 1'b0;

        // 6: PC wrap from RESET_PC=0xFFFFFFF8, then reset mid-stream.
        cur_test = "t6";
        do_reset(1'b1, 32'hFFFF_FFF8);
        exp_addr.push_back(32'hFFFF_FFF8);
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0000_0000);
        exp_addr.push_back(32'h0000_0004);
        exp_dec.push_back('{32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8), 32'hFFFF_FFFC});
        exp_dec.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0000_0000});
        exp_dec.push_back('{32'h0000_0000, mem_word(32'h0000_0000), 32'h0000_0004});
        exp_dec.push_back('{32'h0000_0004, mem_word(32'h0000_0004), 32'h0000_0008});
        dec_ready_in = 1'b1;
        wait_drain(100);
        check("cyc_live", 32'(inst_cyc_out), 32'd1);
        sys_rst = 1'b1;
        tick(1);
        check("midrst_cyc",   32'(inst_cyc_out),  32'd0);
        check("midrst_stb",   32'(inst_stb_out),  32'd0);
        check("midrst_valid", 32'(dec_valid_out), 32'd0);
        check("midrst_addr",  inst_addr_out,      32'hFFFF_FFF8);
        tick(1);
        sys_rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
